ra_mult_param: RTL and testbench

Parametrised repeated-addition multiplier: the next generation of the team's 4-bit repeated-addition (RA) controller/datapath. It multiplies two WIDTH-bit operands by adding the larger-magnitude operand to an accumulator, once per cycle, min(|A|,|B|) times. It supports signed (two's-complement) and unsigned modes, abort, and zero-operand early exit. It exposes the counter-control strobes (cntclr, cnten) for the existing debug/monitor logic and sits as a self-contained arithmetic unit on the datapath bus.

---
 rtl/ra_mult_param.sv | 110 +++++++++++
 tb/tb_ra_mult_param.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ra_mult_param.sv
// Repeated-addition multiplier: adds the larger operand magnitude once per cycle,
// min(|a|,|b|) times, with signed/unsigned modes, abort and zero-operand early exit.
module ra_mult_param #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 clear_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    input  logic                 abort,
    output logic [2*WIDTH-1:0]   product,
    output logic                 done,
    output logic                 busy,
    output logic                 cntclr,
    output logic                 cnten
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_ADD  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]         state;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic               sm_r;
    logic               sign;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;

    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               a_is_big;
    logic [WIDTH-1:0]   mag_min;
    logic [2*WIDTH-1:0] acc_sum;

    // The most negative operand negates to itself, which read unsigned is its magnitude.
    always_comb begin
        mag_a    = (sm_r && a_r[WIDTH-1]) ? -a_r : a_r;
        mag_b    = (sm_r && b_r[WIDTH-1]) ? -b_r : b_r;
        a_is_big = (mag_a >= mag_b);
        mag_min  = a_is_big ? mag_b : mag_a;
        acc_sum  = acc + {{WIDTH{1'b0}}, addend};
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state   <= S_IDLE;
            a_r     <= '0;
            b_r     <= '0;
            sm_r    <= 1'b0;
            sign    <= 1'b0;
            addend  <= '0;
            cnt     <= '0;
            acc     <= '0;
            product <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_r   <= a;
                        b_r   <= b;
                        sm_r  <= signed_mode;
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else begin
                        sign   <= sm_r & (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
                        acc    <= '0;
                        addend <= a_is_big ? mag_a : mag_b;
                        cnt    <= mag_min;
                        if (mag_min == '0) begin
                            product <= '0;
                            state   <= S_DONE;
                        end else begin
                            state   <= S_ADD;
                        end
                    end
                end
                S_ADD: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else begin
                        acc <= acc_sum;
                        cnt <= cnt - WIDTH'(1);
                        // Last iteration: the product takes the sum including this addition.
                        if (cnt == WIDTH'(1)) begin
                            product <= sign ? -acc_sum : acc_sum;
                            state   <= S_DONE;
                        end
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign done   = (state == S_DONE);
    assign busy   = (state != S_IDLE);
    assign cntclr = (state == S_LOAD);
    assign cnten  = (state == S_ADD);

endmodule

// File: tb/tb_ra_mult_param.sv
// Self-checking bench for ra_mult_param: directed cases plus randomized operands
// compared with an arithmetic reference model.
module tb_ra_mult_param;

    localparam int W = 4;

    logic             clk;
    logic             clear_n;
    logic             start;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             signed_mode;
    logic             abort;
    logic [2*W-1:0]   product;
    logic             done;
    logic             busy;
    logic             cntclr;
    logic             cnten;

    int n_tests = 0;
    int n_fail  = 0;
    logic [2*W-1:0] exp_q[$];

    ra_mult_param #(.WIDTH(W)) dut (
        .clk(clk), .clear_n(clear_n), .start(start), .a(a), .b(b),
        .signed_mode(signed_mode), .abort(abort), .product(product),
        .done(done), .busy(busy), .cntclr(cntclr), .cnten(cnten)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input longint obs, input longint req);
        n_tests++;
        if (obs !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", tag, obs, obs, req, req);
        end
    endtask

    // reference model: plain integer arithmetic on the operand values
    function automatic longint sval(input logic [W-1:0] x, input logic sm);
        longint v;
        v = longint'(x);
        if (sm && x[W-1]) v = v - (longint'(1) << W);
        return v;
    endfunction

    function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] x, input logic [W-1:0] y,
                                                 input logic sm);
        longint p;
        logic [2*W-1:0] r;
        p = sval(x, sm) * sval(y, sm);
        r = p[2*W-1:0];
        return r;
    endfunction

    function automatic int ref_n(input logic [W-1:0] x, input logic [W-1:0] y, input logic sm);
        longint mx, my;
        mx = sval(x, sm);
        my = sval(y, sm);
        if (mx < 0) mx = -mx;
        if (my < 0) my = -my;
        return int'((mx < my) ? mx : my);
    endfunction

    // driver: issues one operation and returns at the sample point where done is seen
    task automatic do_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic tsm, output logic [2*W-1:0] prod, output int done_edge);
        int cen, cclr, n;
        logic [2*W-1:0] req;
        exp_q.push_back(ref_prod(ta, tb, tsm));
        n = ref_n(ta, tb, tsm);
        @(negedge clk);
        a = ta; b = tb; signed_mode = tsm; start = 1'b1;
        @(posedge clk);
        done_edge = -1; cen = 0; cclr = 0; prod = '0;
        for (int k = 0; k <= (1 << W) + 4; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (cnten) cen++;
            if (cntclr) cclr++;
            if (k == 0) check({tag, "_busy"}, busy, 1);
            if (done) begin
                done_edge = k;
                prod = product;
                break;
            end
        end
        req = exp_q.pop_front();
        check({tag, "_prod"}, prod, req);
        check({tag, "_done_edge"}, done_edge, n + 1);
        check({tag, "_cnten_cycles"}, cen, n);
        check({tag, "_cntclr_cycles"}, cclr, 1);
    endtask

    logic [2*W-1:0] p;
    int de;
    int done_seen;

    initial begin
        clear_n = 1'b0; start = 1'b0; a = '0; b = '0; signed_mode = 1'b0; abort = 1'b0;
        #1;
        check("rst_product", product, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_cntclr", cntclr, 0);
        check("rst_cnten", cnten, 0);
        #20 clear_n = 1'b1;

        do_op("u8x3", 4'd8, 4'd3, 1'b0, p, de);
        check("u8x3_lit", p, 8'h18);
        check("u8x3_edge", de, 4);

        do_op("u7x4", 4'd7, 4'd4, 1'b0, p, de);
        check("u7x4_lit", p, 8'h1C);
        check("u7x4_edge", de, 5);
        // start raised during DONE must not be taken
        a = 4'd15; b = 4'd15; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("b2b_ignored_busy", busy, 0);
        check("b2b_ignored_done", done, 0);
        @(negedge clk);
        check("b2b_still_idle", busy, 0);
        do_op("u15x15", 4'd15, 4'd15, 1'b0, p, de);
        check("u15x15_lit", p, 8'hE1);

        do_op("u0x9", 4'd0, 4'd9, 1'b0, p, de);
        check("u0x9_edge", de, 1);
        check("u0x9_lit", p, 0);

        do_op("s_m8x3", 4'b1000, 4'd3, 1'b1, p, de);
        check("s_m8x3_lit", p, 8'hE8);
        do_op("s_m8xm8", 4'b1000, 4'b1000, 1'b1, p, de);
        check("s_m8xm8_lit", p, 8'h40);
        check("s_m8xm8_edge", de, 9);

        // abort mid-ADD: sampled at edge 3
        @(negedge clk);
        a = 4'd9; b = 4'd9; signed_mode = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_product_held", product, 8'h40);
        done_seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("abort_no_done", done_seen, 0);

        // asynchronous reset mid-ADD
        @(negedge clk);
        a = 4'd6; b = 4'd6; start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_pre_cnten", cnten, 1);
        #2 clear_n = 1'b0;
        #1;
        check("rst_mid_product", product, 0);
        check("rst_mid_done", done, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_cntclr", cntclr, 0);
        check("rst_mid_cnten", cnten, 0);
        @(negedge clk);
        clear_n = 1'b1;

        do_op("u5x5", 4'd5, 4'd5, 1'b0, p, de);
        check("u5x5_lit", p, 25);
        do_op("s_m1x0", 4'hF, 4'd0, 1'b1, p, de);
        check("s_m1x0_lit", p, 0);

        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra, rb;
            logic rsm;
            ra  = W'($urandom_range(0, (1 << W) - 1));
            rb  = W'($urandom_range(0, (1 << W) - 1));
            rsm = 1'($urandom_range(0, 1));
            do_op("rand", ra, rb, rsm, p, de);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
